// File: rtl/mem_scan_engine.sv
// Seed scanner over a DDR region with a per-beat hit FIFO; reverse-complement strand via MEM_SCAN_REVCOMP_EN.
// Latency: beat sampled at edge t lands in the hit FIFO at edge t+2 (first-word-fall-through).
// Backpressure: bursts issue only when FIFO occupancy plus in-flight beats leaves room for a full burst.

// Generic FIFO, first-word-fall-through, sync active-low reset.
// Latency: write at edge t is visible on out_dat after t. Backpressure: none, caller guarantees space.
// A pop on an empty FIFO is ignored; push and pop may coincide on a full FIFO.
module hit_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [W-1:0]     in_dat,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [W-1:0]     out_dat,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW-1:0] PTR_ONE = 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          pop;

  assign out_vld = (count != '0);
  assign pop     = out_rdy && out_vld;
  assign out_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (in_vld) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)    rd_ptr <= rd_ptr + PTR_ONE;
      case ({in_vld, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (in_vld) mem[wr_ptr] <= in_dat;
  end
endmodule

module mem_scan_engine #(
  parameter int DATA_W      = 512,
  parameter int ADDR_W      = 32,
  parameter int QUERY_W     = 512,
  parameter int SEED_NT     = 11,
  parameter int BURST_BEATS = 4,
  parameter int HIT_DEPTH   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [QUERY_W-1:0] query,
  input  logic              queryValid,
  input  logic [ADDR_W-1:0] dbBase,
  input  logic [31:0]       dbLen,
  output logic              ddr_rd,
  output logic [ADDR_W-1:0] readAdd,
  input  logic              ddr_rd_valid,
  input  logic [DATA_W-1:0] ddr_rd_data,
  input  logic              ddr_rd_done,
  output logic              hitValid,
  input  logic              hitRd,
  output logic [31:0]       locationStart,
  output logic [31:0]       locationEnd,
  output logic              hitMulti,
  output logic              hitStrand,
  output logic              busy,
  output logic              scanDone
);
  localparam int NT      = DATA_W / 2;
  localparam int TAIL_NT = SEED_NT - 1;
  localparam int SEED_W  = 2 * SEED_NT;
  localparam int EXT_W   = 2 * (NT + TAIL_NT);
  localparam int CNT_W   = $clog2(HIT_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_BEATS * DATA_W / 8);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CREDIT, S_REQ, S_NEXT, S_DRAIN, S_FIN
  } state_t;

  typedef struct packed {
    logic [31:0] start;
    logic        multi;
    logic        strand;
  } hit_t;

  state_t              state, state_nxt;
  logic [SEED_W-1:0]   seed;
  logic [31:0]         len;
  logic [ADDR_W-1:0]   next_addr;
  logic [32:0]         issued;
  logic [31:0]         beat_cnt;
  logic [2*TAIL_NT-1:0] tail;
  logic                drain_cnt;
  logic                credit_ok;
  logic                beat_keep;

  logic                s1_vld;
  logic [EXT_W-1:0]    s1_ext;
  logic [31:0]         s1_b;
  logic [NT-1:0]       fwd_c, rev_c;

  logic                s2_vld;
  logic [NT-1:0]       s2_fwd, s2_rev;
  logic [31:0]         s2_b;
  logic [31:0]         sel_k;
  logic                sel_strand, any_m, multi_m;

  hit_t                hit_in, hit_out;
  logic                fifo_vld;
  logic [CNT_W-1:0]    fifo_count;

  if (QUERY_W > SEED_W) begin : g_unused
    logic unused_query;
    assign unused_query = ^query[QUERY_W-1:SEED_W];
  end

  assign credit_ok = (32'(fifo_count) + 32'(s1_vld) + 32'(s2_vld))
                     <= 32'(HIT_DEPTH - BURST_BEATS);
  assign beat_keep = (state == S_REQ) && ddr_rd_valid && (beat_cnt < len);

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ddr_rd    = 1'b0;
    scanDone  = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE:   if (queryValid) state_nxt = S_LOAD;
      S_LOAD:   state_nxt = (len == 32'd0) ? S_FIN : S_CREDIT;
      S_CREDIT: if (credit_ok) state_nxt = S_REQ;
      S_REQ: begin
        ddr_rd = 1'b1;
        if (ddr_rd_done) state_nxt = S_NEXT;
      end
      S_NEXT:   state_nxt = (issued < {1'b0, len}) ? S_CREDIT : S_DRAIN;
      S_DRAIN:  if (drain_cnt) state_nxt = S_FIN;
      S_FIN: begin
        scanDone  = 1'b1;
        state_nxt = S_IDLE;
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      seed      <= '0;
      len       <= '0;
      next_addr <= '0;
      issued    <= '0;
      beat_cnt  <= '0;
      tail      <= '0;
      drain_cnt <= 1'b0;
      readAdd   <= '0;
      s1_vld    <= 1'b0;
      s1_ext    <= '0;
      s1_b      <= '0;
      s2_vld    <= 1'b0;
      s2_fwd    <= '0;
      s2_rev    <= '0;
      s2_b      <= '0;
    end else begin
      if (state == S_IDLE && queryValid) begin
        seed      <= query[SEED_W-1:0];
        len       <= dbLen;
        next_addr <= dbBase;
      end
      if (state == S_LOAD) begin
        issued   <= '0;
        beat_cnt <= '0;
        tail     <= '0;
      end
      if (state == S_CREDIT && credit_ok) begin
        readAdd   <= next_addr;
        next_addr <= next_addr + BURST_BYTES;
        issued    <= issued + 33'(BURST_BEATS);
      end
      drain_cnt <= (state == S_DRAIN) ? ~drain_cnt : 1'b0;
      if (state == S_REQ && ddr_rd_valid) beat_cnt <= beat_cnt + 32'd1;

      // Overrun beats past len never enter the pipeline and leave the tail untouched.
      s1_vld <= beat_keep;
      if (beat_keep) begin
        s1_ext <= {ddr_rd_data, tail};
        s1_b   <= beat_cnt;
        tail   <= ddr_rd_data[DATA_W-1 -: 2*TAIL_NT];
      end

      s2_vld <= s1_vld;
      s2_fwd <= fwd_c;
      s2_rev <= rev_c;
      s2_b   <= s1_b;
    end
  end

`ifdef MEM_SCAN_REVCOMP_EN
  logic [SEED_W-1:0] rc_seed;
  always_comb begin
    rc_seed = '0;
    for (int j = 0; j < SEED_NT; j++)
      rc_seed[2*j +: 2] = ~seed[2*(SEED_NT-1-j) +: 2];
  end
`endif

  // Window k spans ext nucleotides k..k+SEED_NT-1; the first TAIL_NT windows of beat 0 start before the region.
  always_comb begin
    fwd_c = '0;
    rev_c = '0;
    for (int k = 0; k < NT; k++) begin
      if (!(s1_b == 32'd0 && k < TAIL_NT)) begin
        fwd_c[k] = (s1_ext[2*k +: SEED_W] == seed);
`ifdef MEM_SCAN_REVCOMP_EN
        rev_c[k] = (s1_ext[2*k +: SEED_W] == rc_seed);
`endif
      end
    end
  end

  always_comb begin
    sel_k      = '0;
    sel_strand = 1'b0;
    for (int k = NT - 1; k >= 0; k--) begin
      if (s2_fwd[k] || s2_rev[k]) begin
        sel_k      = 32'(k);
        sel_strand = ~s2_fwd[k];
      end
    end
  end

  assign any_m   = |(s2_fwd | s2_rev);
  assign multi_m = (|(s2_fwd & (s2_fwd - NT'(1)))) || (|(s2_rev & (s2_rev - NT'(1))))
                   || ((|s2_fwd) && (|s2_rev));

  always_comb begin
    hit_in        = '0;
    hit_in.start  = s2_b * 32'(NT) + sel_k - 32'(TAIL_NT);
    hit_in.multi  = multi_m;
    hit_in.strand = sel_strand;
  end

  hit_fifo #(
    .W     ($bits(hit_t)),
    .DEPTH (HIT_DEPTH)
  ) u_hit_fifo (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (s2_vld && any_m),
    .in_dat  (hit_in),
    .out_vld (fifo_vld),
    .out_rdy (hitRd),
    .out_dat (hit_out),
    .count   (fifo_count)
  );

  assign hitValid      = fifo_vld;
  assign locationStart = fifo_vld ? hit_out.start : 32'd0;
  assign locationEnd   = fifo_vld ? hit_out.start + 32'(TAIL_NT) : 32'd0;
  assign hitMulti      = fifo_vld && hit_out.multi;
  assign hitStrand     = fifo_vld && hit_out.strand;
endmodule

// File: tb/tb_mem_scan_engine.sv
// Directed bench for mem_scan_engine: DATA_W=64, SEED_NT=4, BURST_BEATS=2, HIT_DEPTH=4.
module tb_mem_scan_engine;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] query = 32'h1B;
  logic        queryValid = 1'b0;
  logic [31:0] dbBase = '0;
  logic [31:0] dbLen = '0;
  logic        ddr_rd;
  logic [31:0] readAdd;
  logic        ddr_rd_valid = 1'b0;
  logic [63:0] ddr_rd_data = '0;
  logic        ddr_rd_done = 1'b0;
  logic        hitValid;
  logic        hitRd = 1'b0;
  logic [31:0] locationStart, locationEnd;
  logic        hitMulti, hitStrand, busy, scanDone;

  int n_chk  = 0;
  int n_pass = 0;
  logic [63:0] beat_mem [0:7];

  always #5 clk = ~clk;

  mem_scan_engine #(
    .DATA_W(64), .ADDR_W(32), .QUERY_W(32), .SEED_NT(4), .BURST_BEATS(2), .HIT_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .query(query), .queryValid(queryValid),
    .dbBase(dbBase), .dbLen(dbLen), .ddr_rd(ddr_rd), .readAdd(readAdd),
    .ddr_rd_valid(ddr_rd_valid), .ddr_rd_data(ddr_rd_data), .ddr_rd_done(ddr_rd_done),
    .hitValid(hitValid), .hitRd(hitRd), .locationStart(locationStart),
    .locationEnd(locationEnd), .hitMulti(hitMulti), .hitStrand(hitStrand),
    .busy(busy), .scanDone(scanDone)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic start_scan(input logic [31:0] base, input logic [31:0] len);
    @(negedge clk);
    queryValid = 1'b1;
    dbBase     = base;
    dbLen      = len;
    @(negedge clk);
    queryValid = 1'b0;
  endtask

  task automatic serve_burst(input int first, input logic [31:0] exp_addr, input string tag,
                             output int lat);
    lat = 0;
    while (!ddr_rd && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    if (!ddr_rd) begin
      check({tag, "_rd_timeout"}, 64'd0, 64'd1);
      return;
    end
    check({tag, "_addr"}, readAdd, exp_addr);
    for (int i = 0; i < 2; i++) begin
      ddr_rd_valid = 1'b1;
      ddr_rd_data  = beat_mem[first + i];
      ddr_rd_done  = (i == 1);
      @(negedge clk);
    end
    ddr_rd_valid = 1'b0;
    ddr_rd_done  = 1'b0;
    ddr_rd_data  = '0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!scanDone && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!scanDone) n = -1;
  endtask

  task automatic pop_check(input string tag, input logic [31:0] st, input logic multi,
                           input logic strand);
    check({tag, "_vld"}, hitValid, 1'b1);
    check({tag, "_start"}, locationStart, st);
    check({tag, "_end"}, locationEnd, st + 32'd3);
    check({tag, "_multi"}, hitMulti, multi);
    check({tag, "_strand"}, hitStrand, strand);
    hitRd = 1'b1;
    @(negedge clk);
    hitRd = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, n;
    logic rd_seen;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ddr_rd", ddr_rd, 1'b0);
    check("rst_readAdd", readAdd, 32'd0);
    check("rst_hitValid", hitValid, 1'b0);
    check("rst_start", locationStart, 32'd0);
    check("rst_end", locationEnd, 32'd0);
    check("rst_multi", hitMulti, 1'b0);
    check("rst_strand", hitStrand, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_scanDone", scanDone, 1'b0);
    rst = 1'b1;

    // Single hit, with latency of read issue, hit write and scanDone
    beat_mem[0] = 64'h1B; beat_mem[1] = 64'h0;
    start_scan(32'h1000, 32'd2);
    check("t1_busy", busy, 1'b1);
    serve_burst(0, 32'h1000, "t1", lat);
    check("t1_rd_lat", 64'(lat), 64'd2);
    check("t1_rd_fall", ddr_rd, 1'b0);
    check("t1_hit_early", hitValid, 1'b0);
    @(negedge clk);
    check("t1_hit_lat", hitValid, 1'b1);
    wait_done(n);
    check("t1_done_lat", 64'(n), 64'd2);
    pop_check("t1", 32'd0, 1'b0, 1'b0);
    check("t1_empty", hitValid, 1'b0);

    // Window spanning the beat boundary
    beat_mem[0] = 64'hB000_0000_0000_0000; beat_mem[1] = 64'h1;
    start_scan(32'h2000, 32'd2);
    serve_burst(0, 32'h2000, "t2", lat);
    wait_done(n);
    check("t2_done", 64'(n >= 0), 64'd1);
    pop_check("t2", 32'd30, 1'b0, 1'b0);
    check("t2_empty", hitValid, 1'b0);

    // Two matches in one beat; overrun beat 1 must be discarded
    beat_mem[0] = 64'h1B1B; beat_mem[1] = 64'h1B;
    start_scan(32'h1000, 32'd1);
    serve_burst(0, 32'h1000, "t3", lat);
    wait_done(n);
    pop_check("t3", 32'd0, 1'b1, 1'b0);
    check("t3_overrun", hitValid, 1'b0);

    // Backpressure: FIFO fills after two bursts, third burst waits for pops
    for (int i = 0; i < 6; i++) beat_mem[i] = 64'h1B;
    start_scan(32'h1000, 32'd6);
    serve_burst(0, 32'h1000, "t4a", lat);
    serve_burst(2, 32'h1010, "t4b", lat);
    rd_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rd_seen |= ddr_rd;
    end
    check("t4_hold_rd", rd_seen, 1'b0);
    check("t4_hold_addr", readAdd, 32'h1010);
    pop_check("t4_p0", 32'd0, 1'b0, 1'b0);
    pop_check("t4_p1", 32'd32, 1'b0, 1'b0);
    serve_burst(4, 32'h1020, "t4c", lat);
    wait_done(n);
    check("t4_done", 64'(n >= 0), 64'd1);
    pop_check("t4_p2", 32'd64, 1'b0, 1'b0);
    pop_check("t4_p3", 32'd96, 1'b0, 1'b0);
    pop_check("t4_p4", 32'd128, 1'b0, 1'b0);
    pop_check("t4_p5", 32'd160, 1'b0, 1'b0);
    check("t4_empty", hitValid, 1'b0);

    // Zero-length region
    start_scan(32'h4000, 32'd0);
    check("t5_done0", scanDone, 1'b0);
    check("t5_rd0", ddr_rd, 1'b0);
    @(negedge clk);
    check("t5_done1", scanDone, 1'b1);
    check("t5_rd1", ddr_rd, 1'b0);
    @(negedge clk);
    check("t5_done2", scanDone, 1'b0);
    check("t5_busy2", busy, 1'b0);
    check("t5_rd2", ddr_rd, 1'b0);

    // Reset asserted while beat 1 is on the bus
    start_scan(32'h3000, 32'd4);
    lat = 0;
    while (!ddr_rd && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check("t6_rd", ddr_rd, 1'b1);
    ddr_rd_valid = 1'b1; ddr_rd_data = 64'h1B;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t6_ddr_rd", ddr_rd, 1'b0);
    check("t6_readAdd", readAdd, 32'd0);
    check("t6_hitValid", hitValid, 1'b0);
    check("t6_busy", busy, 1'b0);
    check("t6_scanDone", scanDone, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ddr_rd_done = (i == 1);
      @(negedge clk);
    end
    ddr_rd_valid = 1'b0; ddr_rd_done = 1'b0; ddr_rd_data = '0;
    repeat (3) @(negedge clk);
    check("t6_no_entry", hitValid, 1'b0);
    check("t6_idle", busy, 1'b0);

    // Reverse-complement seed match
    query = 32'h40;
    beat_mem[0] = 64'hFE; beat_mem[1] = 64'hFE;
    start_scan(32'h5000, 32'd1);
    serve_burst(0, 32'h5000, "t7", lat);
    wait_done(n);
    check("t7_done", 64'(n >= 0), 64'd1);
`ifdef MEM_SCAN_REVCOMP_EN
    pop_check("t7", 32'd0, 1'b0, 1'b1);
`endif
    check("t7_empty", hitValid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_scan_engine.md
# mem_scan_engine

- Parametrised successor to the single-query DDR memory interface; sits between the DDR read port and the hit-extension stage.
- Takes one query seed and a database region (base address, length in beats), then issues burst reads across the region.
- Compares every 2-bit-encoded nucleotide window of each returned beat against the seed, including windows that span beat boundaries.
- Queues one hit record per beat in an internal FIFO; read issue is throttled so the FIFO never overflows.

## Interface
- DATA_W, 512, DDR beat width (even; NT = DATA_W/2 nucleotides per beat)
- ADDR_W, 32, DDR byte address width
- QUERY_W, 512, query bus width
- SEED_NT, 11, seed length in nucleotides (2 ≤ SEED_NT ≤ NT)
- BURST_BEATS, 4, beats per DDR read request
- HIT_DEPTH, 8, hit FIFO depth (power of 2, ≥ BURST_BEATS)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- query  in  QUERY_W  seed in query[2*SEED_NT-1:0]; nucleotide j = bits [2j+1:2j]
- queryValid  in  1  start scan (sampled in IDLE only)
- dbBase  in  ADDR_W  region start byte address (sampled with queryValid)
- dbLen  in  32  region length in beats (sampled with queryValid)
- ddr_rd  out  1  read request, held until ddr_rd_done
- readAdd  out  ADDR_W  burst start byte address
- ddr_rd_valid  in  1  beat valid
- ddr_rd_data  in  DATA_W  beat data; nucleotide i = bits [2i+1:2i]
- ddr_rd_done  in  1  asserted with the last beat of the burst
- hitValid  out  1  FIFO non-empty
- hitRd  in  1  pop head entry (ignored when empty)
- locationStart  out  32  global nucleotide index of first window nucleotide
- locationEnd  out  32  locationStart + SEED_NT − 1
- hitMulti  out  1  more than one window in that beat matched
- hitStrand  out  1  0 = forward, 1 = reverse complement
- busy  out  1  state ≠ IDLE
- scanDone  out  1  one-cycle pulse at end of scan

## Operation
- States:
  - IDLE → (queryValid) LOAD.
  - LOAD: capture seed, base, len; clear beat counter and tail register. If len = 0 → FIN, else → CREDIT.
  - CREDIT → REQ when fifoCount + pendingHits ≤ HIT_DEPTH − BURST_BEATS.
  - REQ: ddr_rd = 1; readAdd = base + burstIdx·BURST_BEATS·DATA_W/8, modulo 2^ADDR_W. → (ddr_rd_done) NEXT.
  - NEXT → CREDIT if beats remain, else DRAIN.
  - DRAIN: 2 cycles to empty the pipeline → FIN.
  - FIN: scanDone = 1 → IDLE.
- Beat numbering: global beat b. Window ending at global nucleotide g = b·NT + i covers g−SEED_NT+1 … g and matches when db[start+j] == seed[j] for all j.
  - The previous beat's top SEED_NT−1 nucleotides are kept as a tail for spanning windows.
  - Windows with start < 0 are excluded.
- Beats with b ≥ len (final burst overrun) are discarded: no compare, no tail update.
- Per beat: report the lowest-start matching window; set hitMulti if ≥2 windows matched. Zero matches → no FIFO write.
- FIFO is first-word-fall-through. A pop on a full FIFO is legal. A push is never blocked: the credit scheme guarantees space.
- The FIFO is not flushed between scans. queryValid while busy is ignored.
- ddr_rd_valid/done outside REQ are ignored.

## Timing
- Reset values: ddr_rd 0, readAdd 0, hitValid 0, locationStart/End 0, hitMulti 0, hitStrand 0, busy 0, scanDone 0. FIFO, counters and tail are cleared.
- Reset mid-scan: block returns to IDLE on the next edge; in-flight beats are dropped.
- queryValid sampled at edge t → LOAD in t+1. ddr_rd rises at edge t+2 when credit allows.
- Hit latency: beat sampled at edge t is registered at t; compare and priority encode run in t+1; FIFO write at edge t+2; hitValid is high in the cycle after t+2.
- len = 0: scanDone pulses 2 cycles after the queryValid edge; ddr_rd is never asserted.
- ddr_rd falls on the edge after ddr_rd_done is sampled.

## Configuration
- MEM_SCAN_REVCOMP_EN defined:
  - Each window is also compared against the reverse complement of the seed: rc[j] = ~seed[SEED_NT−1−j].
  - A reverse match sets hitStrand = 1.
  - If the same window matches both strands, forward wins.
  - Forward and reverse matches both count toward hitMulti.
- Not defined: reverse comparators are absent and hitStrand is tied 0.

## Test plan
Bench config: DATA_W=64, SEED_NT=4, BURST_BEATS=2, HIT_DEPTH=4, query=0x1B.

- Single hit: dbBase=0x1000, dbLen=2, beat0=0x1B, beat1=0 → readAdd=0x1000; exactly one entry: start 0, end 3, hitMulti 0; scanDone after DRAIN.
- Boundary span: beat0=0xB000_0000_0000_0000, beat1=0x1 → one entry: start 30, end 33.
- Multi-hit: beat0=0x1B1B → one entry: start 0, hitMulti 1.
- Backpressure: dbLen=6, every beat 0x1B, no hitRd → after 4 entries ddr_rd stays 0 and readAdd stays 0x1010. Popping 2 entries releases the third burst.
- Edge cases:
  - dbLen=0 → no ddr_rd; scanDone 2 cycles after queryValid.
  - rst low during beat 1 → all outputs at reset values next cycle; later beats produce no entries.
- MEM_SCAN_REVCOMP_EN, query=0x40, beat0=0xFE → entry: start 0, hitStrand 1. Same stimulus without the macro → no entry.
